// File: rtl/fifo_uart_tx_if.sv
// Read port between a sync FIFO and the UART transmitter that drains it.
// master = the reader (drives rd_en); slave = the FIFO (drives valid/data).
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             rd_en;

    modport master (input valid, input data, output rd_en);
    modport slave  (output valid, output data, input rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter: pops one FIFO word per frame, sends start, data LSB-first,
// optional parity and stop bits, each bit exactly CLK_DIV clocks long.
module fifo_uart_tx #(
    parameter int WIDTH      = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           nrst,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               rd_en_q, rd_en_d;
    logic               done_q, done_d;
    logic               bit_end;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        bit_end = (baud_q == BAUD_W'(CLK_DIV - 1));
        baud_d  = bit_end ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (fifo.valid) begin
                    rd_en_d = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                // The registered pop lands its word one cycle after rd_en,
                // which is the first START cycle; data is not needed until DATA.
                if (baud_q == '0) begin
                    sh_d  = fifo.data;
                    par_d = (^fifo.data) ^ 1'(PARITY_ODD);
                end
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_d = sh_q >> 1;
                    if (bit_q == BIT_W'(WIDTH - 1)) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) state_d = PARITY;
                        else                state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so tx stays a plain flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
        end
    end

    assign tx         = tx_q;
    assign fifo.rd_en = rd_en_q;
    assign tx_done    = done_q;
    assign busy       = (state_q != IDLE);
endmodule
